// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with pedestrian walk and night flash.
// Each phase runs on a down-counter loaded with (length - 1) on entry.
// All outputs are registered and decoded from the next state, so they are
// a pure function of the state the controller is in.
module traffic_light_ctrl #(
   parameter int GREEN_T   = 20,
   parameter int YELLOW_T  = 4,
   parameter int ALLRED_T  = 2,
   parameter int MIN_GREEN = 5,
   parameter int WALK_T    = 8,
   parameter int FLASH_T   = 4,
   parameter int CNT_W     = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [0:2] light_ns,
   output logic [0:2] light_ew,
   output logic       ped_walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      RED_A  = 3'd2,
      EW_GRN = 3'd3,
      EW_YEL = 3'd4,
      RED_B  = 3'd5,
      FLASH  = 3'd6,
      BAD    = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] W_LD  = CNT_W'(WALK_T - 1);
   localparam logic [CNT_W-1:0] F_LD  = CNT_W'(FLASH_T - 1);
   // Green may be cut short once the counter has fallen to this value,
   // i.e. once MIN_GREEN cycles of green have been shown.
   localparam int CUT_AT = GREEN_T - MIN_GREEN;

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic             pending, nxt_pending;
   logic             blink, nxt_blink;
   logic             walk, nxt_walk;
   logic             cnt_zero, cut_ok;

   assign cnt_zero = (cnt == '0);
   assign cut_ok   = pending && (CUT_AT >= 0) && (int'(cnt) <= CUT_AT);

   function automatic logic [0:2] ns_of(input state_t s, input logic b);
      case (s)
         NS_GRN:  ns_of = 3'b010;
         NS_YEL:  ns_of = 3'b001;
         FLASH:   ns_of = b ? 3'b001 : 3'b000;
         default: ns_of = 3'b100;
      endcase
   endfunction

   function automatic logic [0:2] ew_of(input state_t s, input logic b);
      case (s)
         EW_GRN:  ew_of = 3'b010;
         EW_YEL:  ew_of = 3'b001;
         FLASH:   ew_of = b ? 3'b100 : 3'b000;
         default: ew_of = 3'b100;
      endcase
   endfunction

   // Next-state, counter, pedestrian latch and blink decisions.
   always_comb begin
      nxt_state   = state;
      nxt_cnt     = cnt - CNT_W'(1);
      nxt_pending = pending | ped_req;
      nxt_blink   = blink;
      nxt_walk    = walk;
      case (state)
         NS_GRN, EW_GRN: begin
            if (cnt_zero || cut_ok) begin
               nxt_state = (state == NS_GRN) ? NS_YEL : EW_YEL;
               nxt_cnt   = Y_LD;
            end
         end
         NS_YEL, EW_YEL: begin
            if (cnt_zero) begin
               nxt_state = (state == NS_YEL) ? RED_A : RED_B;
               // A pending request is served here; a new request on this
               // same edge stays latched for the next all-red.
               if (pending) begin
                  nxt_cnt     = W_LD;
                  nxt_walk    = 1'b1;
                  nxt_pending = ped_req;
               end else begin
                  nxt_cnt  = AR_LD;
                  nxt_walk = 1'b0;
               end
            end
         end
         RED_A, RED_B: begin
            if (cnt_zero) begin
               nxt_walk = 1'b0;
               if (night_mode) begin
                  nxt_state = FLASH;
                  nxt_cnt   = F_LD;
                  nxt_blink = 1'b1;
               end else begin
                  nxt_state = (state == RED_A) ? EW_GRN : NS_GRN;
                  nxt_cnt   = G_LD;
               end
            end
         end
         FLASH: begin
            if (cnt_zero) begin
               if (!night_mode) begin
                  nxt_state = RED_B;
                  nxt_blink = 1'b0;
                  if (pending) begin
                     nxt_cnt     = W_LD;
                     nxt_walk    = 1'b1;
                     nxt_pending = ped_req;
                  end else begin
                     nxt_cnt  = AR_LD;
                     nxt_walk = 1'b0;
                  end
               end else begin
                  nxt_blink = ~blink;
                  nxt_cnt   = F_LD;
               end
            end
         end
         default: begin
            nxt_state = RED_B;
            nxt_cnt   = AR_LD;
            nxt_walk  = 1'b0;
         end
      endcase
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RED_B;
         cnt      <= AR_LD;
         pending  <= 1'b0;
         blink    <= 1'b0;
         walk     <= 1'b0;
         light_ns <= 3'b100;
         light_ew <= 3'b100;
         ped_walk <= 1'b0;
         phase    <= RED_B;
      end else begin
         state    <= nxt_state;
         cnt      <= nxt_cnt;
         pending  <= nxt_pending;
         blink    <= nxt_blink;
         walk     <= nxt_walk;
         light_ns <= ns_of(nxt_state, nxt_blink);
         light_ew <= ew_of(nxt_state, nxt_blink);
         ped_walk <= nxt_walk && (nxt_state == RED_A || nxt_state == RED_B);
         phase    <= nxt_state;
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl. A phase/age reference model
// predicts the outputs for every cycle; the stimulus side pushes them into
// a queue and a negedge monitor pops and compares them against the DUT.
module tb_traffic_light_ctrl;

   localparam int GT = 6, YT = 2, ART = 1, MG = 3, WT = 4, FT = 2;

   logic       clock = 1'b0;
   logic       reset_n, ped_req, night_mode;
   logic [0:2] light_ns, light_ew;
   logic       ped_walk;
   logic [2:0] phase;

   traffic_light_ctrl #(
      .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(ART), .MIN_GREEN(MG),
      .WALK_T(WT), .FLASH_T(FT), .CNT_W(8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .ped_req(ped_req),
      .night_mode(night_mode), .light_ns(light_ns), .light_ew(light_ew),
      .ped_walk(ped_walk), .phase(phase)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
      logic       walk;
      logic [2:0] ph;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_e, mon_a;
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: current phase, its length and the cycle number in it.
   int m_ph, m_len, m_age;
   bit m_pend, m_blink, m_walk;

   function automatic void model_reset();
      m_ph = 5; m_len = ART; m_age = 1;
      m_pend = 0; m_blink = 0; m_walk = 0;
   endfunction

   function automatic void enter_red(input int p, input bit req);
      m_ph = p; m_age = 1;
      if (m_pend) begin
         m_len = WT; m_walk = 1; m_pend = req;
      end else begin
         m_len = ART; m_walk = 0; m_pend = req;
      end
   endfunction

   function automatic void model_edge(input bit req, input bit night);
      bit done;
      done = (m_age >= m_len);
      if ((m_ph == 0 || m_ph == 3) && m_pend && m_age >= MG) done = 1;
      if (!done) begin
         m_age++;
         m_pend = m_pend | req;
         return;
      end
      case (m_ph)
         0, 3: begin
            m_ph = m_ph + 1; m_len = YT; m_age = 1; m_pend = m_pend | req;
         end
         1: enter_red(2, req);
         4: enter_red(5, req);
         2, 5: begin
            m_walk = 0; m_age = 1; m_pend = m_pend | req;
            if (night) begin
               m_ph = 6; m_len = FT; m_blink = 1;
            end else begin
               m_ph = (m_ph == 2) ? 3 : 0; m_len = GT;
            end
         end
         default: begin
            if (!night) begin
               m_blink = 0;
               if (!m_pend) m_pend = 0;
               enter_red(5, req | 1'b0);
            end else begin
               m_blink = !m_blink; m_age = 1; m_pend = m_pend | req;
            end
         end
      endcase
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      o.ph = 3'(m_ph);
      o.walk = m_walk && (m_ph == 2 || m_ph == 5);
      o.ns = 3'b100;
      o.ew = 3'b100;
      case (m_ph)
         0: o.ns = 3'b010;
         1: o.ns = 3'b001;
         3: o.ew = 3'b010;
         4: o.ew = 3'b001;
         6: begin
            o.ns = m_blink ? 3'b001 : 3'b000;
            o.ew = m_blink ? 3'b100 : 3'b000;
         end
         default: ;
      endcase
      return o;
   endfunction

   // Advance the model over the rising edge using the inputs the DUT saw.
   task automatic step_edge();
      @(posedge clock);
      if (reset_n) model_edge(ped_req, night_mode);
      else model_reset();
   endtask

   // Apply the inputs for the coming cycle and queue the expected outputs.
   task automatic drive(input bit p, input bit n, input bit r);
      #1;
      ped_req = p; night_mode = n; reset_n = r;
      if (!r) model_reset();
      exp_q.push_back(model_out());
   endtask

   task automatic cyc(input bit p, input bit n, input bit r);
      step_edge();
      drive(p, n, r);
   endtask

   // Idle until the model reaches (phase, cycle-in-phase); caller then drives.
   task automatic wait_for(input int ph, input int age, input int limit, input bit n);
      int k;
      k = 0;
      step_edge();
      while (!(m_ph == ph && m_age == age) && k < limit) begin
         drive(0, n, 1);
         step_edge();
         k++;
      end
      if (k >= limit) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_for phase=%0d age=%0d not reached, model at %0d/%0d", ph, age, m_ph, m_age);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, plus a conflict check.
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {light_ns, light_ew, ped_walk, phase};
         vectors++;
         if (mon_a !== mon_e) begin
            miscompares++;
            $display("FAIL outputs t=%0t got ns=%b ew=%b walk=%b ph=%0d want ns=%b ew=%b walk=%b ph=%0d",
                     $time, mon_a.ns, mon_a.ew, mon_a.walk, mon_a.ph,
                     mon_e.ns, mon_e.ew, mon_e.walk, mon_e.ph);
         end
         if (phase != 3'd6) begin
            vectors++;
            if (light_ns != 3'b100 && light_ew != 3'b100) begin
               miscompares++;
               $display("FAIL conflict t=%0t got ns=%b ew=%b want one road red", $time, light_ns, light_ew);
            end
         end
      end
   end

   initial begin
      bit rn, rp, rr;
      int rst_left;
      reset_n = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
      model_reset();

      // Reset, release, then plain cycling.
      repeat (3) cyc(0, 0, 0);
      cyc(0, 0, 1);
      repeat (40) cyc(0, 0, 1);

      // One-cycle request in the 2nd NS green cycle cuts green to 3.
      wait_for(0, 2, 40, 0);
      drive(1, 0, 1);
      repeat (30) cyc(0, 0, 1);

      // Request in the last NS green cycle: no extension, walk in RED_A.
      wait_for(0, 6, 40, 0);
      drive(1, 0, 1);
      repeat (30) cyc(0, 0, 1);

      // Night mode raised during EW green, held, then dropped.
      wait_for(3, 2, 40, 0);
      drive(0, 1, 1);
      repeat (30) cyc(0, 1, 1);
      repeat (20) cyc(0, 0, 1);

      // Reset pulsed for 3 cycles in the middle of EW green.
      wait_for(3, 3, 40, 0);
      drive(0, 0, 0);
      repeat (2) cyc(0, 0, 0);
      cyc(0, 0, 1);
      repeat (20) cyc(0, 0, 1);

      // Request during flash is served in the exit RED_B.
      wait_for(0, 1, 40, 0);
      drive(0, 1, 1);
      wait_for(6, 1, 60, 1);
      drive(1, 1, 1);
      repeat (5) cyc(0, 1, 1);
      repeat (20) cyc(0, 0, 1);

      // Random traffic.
      rn = 0;
      rst_left = 0;
      repeat (3000) begin
         rp = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) rn = !rn;
         if (rst_left > 0) begin
            rr = 0;
            rst_left--;
         end else if ($urandom_range(0, 499) == 0) begin
            rr = 0;
            rst_left = $urandom_range(0, 2);
         end else begin
            rr = 1;
         end
         cyc(rp, rn, rr);
      end
      cyc(0, 0, 1);

      repeat (2) @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain got %0d entries left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
